packet_hold_buffer: RTL and testbench
=====================================

PACKET_HOLD_BUFFER -- requirements
Module: packet_hold_buffer

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, the stream data width in bits.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, the stream sideband width in bits.
REQ-003 SHALL have parameter C_FIFO_DEPTH, default 32, the data FIFO depth in beats; it SHALL be a power of 2 and at least 8.
REQ-004 SHALL have parameter C_DEC_DEPTH, default 4, the decision FIFO depth in entries; it SHALL be a power of 2.
REQ-005 axis_clk  in  1  clock; all logic on the rising edge.
REQ-006 aresetn  in  1  reset, synchronous, active-low.
REQ-007 s_axis_tdata/tkeep/tuser/tvalid/tlast  in  DW/DW/8/TW/1/1  ingress stream; the parser taps the same accepted beats.
REQ-008 s_axis_tready  out  1  ingress backpressure.
REQ-009 m_axis_tdata/tkeep/tuser/tvalid/tlast  out  DW/DW/8/TW/1/1  egress stream.
REQ-010 m_axis_tready  in  1  egress backpressure.
REQ-011 parse_valid  in  1  one-cycle pulse, one per packet, in packet order.
REQ-012 parse_drop  in  1  qualified by parse_valid; 1 = discard the packet.
REQ-013 pkt_fwd_cnt, pkt_drop_cnt  out  32 each  packets forwarded and dropped.
REQ-014 err_dec_ovf  out  1  sticky flag: a decision was lost.

Function
REQ-015 A beat SHALL be written to the data FIFO when s_axis_tvalid & s_axis_tready, storing {tdata, tkeep, tuser, tlast}.
REQ-016 s_axis_tready SHALL be 1 exactly when the data FIFO occupancy is less than C_FIFO_DEPTH.
REQ-017 When parse_valid=1, parse_drop SHALL be pushed into the decision FIFO; if that FIFO is full, the push SHALL be discarded and err_dec_ovf set to 1 until reset.
REQ-018 Both FIFOs SHALL be first-word-fall-through with log2(depth)+1-bit pointers that wrap modulo 2*depth; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-019 A simultaneous push and pop SHALL leave occupancy unchanged and be legal when the FIFO is full or when it holds one entry.
REQ-020 FSM states SHALL be IDLE, FWD and DROP; reset state IDLE.
REQ-021 IDLE: when the decision FIFO and the data FIFO are both non-empty, the FSM SHALL pop one decision and go to DROP if it is 1, else FWD.
REQ-022 FWD: m_axis_tvalid SHALL equal data-FIFO non-empty, with m_axis_* driven from the FIFO head; on tvalid&tready the beat SHALL be popped, and popping a tlast beat SHALL increment pkt_fwd_cnt and return to IDLE.
REQ-023 DROP: m_axis_tvalid SHALL be 0 and one beat SHALL be popped per cycle while non-empty; popping a tlast beat SHALL increment pkt_drop_cnt and return to IDLE.
REQ-024 Latency: with a decision and a beat both present at edge N, the first egress beat SHALL be valid in cycle N+1.
REQ-025 m_axis_tdata/tkeep/tuser/tlast SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-026 A decision pulse arriving in the same cycle as the packet's first or last beat SHALL be accepted.
REQ-027 Counters SHALL wrap from 2^32-1 to 0.

Reset
REQ-028 On aresetn=0: pointers and counters SHALL be 0, state IDLE, err_dec_ovf 0, m_axis_tvalid 0 and s_axis_tready 0; FIFO contents are discarded, including when reset is asserted mid-packet.
REQ-029 s_axis_tready SHALL rise in the first cycle after aresetn returns to 1.

Configuration
REQ-030 Macro HOLD_BUF_DROP_EN defined: behaviour is exactly as in REQ-021/023.
REQ-031 HOLD_BUF_DROP_EN undefined: parse_drop SHALL be ignored, every decision SHALL select FWD, the DROP state SHALL be absent, and pkt_drop_cnt SHALL be tied to 0.

Structure
REQ-032 Package hold_buf_pkg SHALL hold the FSM state enum, the default width constants and the FIFO entry record width.
REQ-033 Sub-module hold_buf_fifo (parameterised FWFT FIFO) SHALL be instantiated twice, once for data and once for decisions.

Verification
REQ-034 Single 3-beat packet, parse_valid=1 and parse_drop=0 on beat 1, m_axis_tready=1 -> 3 beats out identical, tlast on beat 3, pkt_fwd_cnt=1.
REQ-035 Two packets with decisions drop,fwd (HOLD_BUF_DROP_EN defined) -> only packet 2 on egress, pkt_drop_cnt=1, pkt_fwd_cnt=1.
REQ-036 m_axis_tready=0 while 32 beats are pushed -> s_axis_tready=0 after beat 32; tready=1 for one cycle -> one pop and s_axis_tready=1 the next cycle.
REQ-037 5 parse_valid pulses with no data -> err_dec_ovf=1 after the 5th, and only 4 decisions are consumed.
REQ-038 aresetn=0 mid-packet (beat 2 of 4) -> tvalid=0 and counts 0; a new packet afterwards forwards correctly.

Source files
------------

// File: rtl/hold_buf_pkg.sv
// Shared types and constants for the packet hold buffer.
//
// Contents:
//   state_e          - hold FSM state encoding (StDrop exists only when HOLD_BUF_DROP_EN is defined)
//   DefDataWidth     - default stream data width in bits
//   DefTuserWidth    - default stream sideband width in bits
//   entry_width()    - width of one data FIFO entry {tdata, tkeep, tuser, tlast}
//   DefEntryWidth    - data FIFO entry width for the default widths
//
// Configuration macro: HOLD_BUF_DROP_EN (defined = drop decisions honoured).

package hold_buf_pkg;

`ifdef HOLD_BUF_DROP_EN
    typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StFwd} state_e;
`endif

    localparam int unsigned DefDataWidth  = 256;
    localparam int unsigned DefTuserWidth = 128;

    function automatic int unsigned entry_width(input int unsigned dw, input int unsigned tw);
        return dw + dw / 8 + tw + 1;
    endfunction

    localparam int unsigned DefEntryWidth = entry_width(DefDataWidth, DefTuserWidth);

endpackage

// File: rtl/hold_buf_fifo.sv
// First-word-fall-through FIFO used for both the beat store and the decision queue.
//
// Pointers are log2(Depth)+1 bits and wrap modulo 2*Depth: equal pointers mean empty,
// differing MSBs with equal low bits mean full. A push together with a pop is accepted
// even when full, leaving occupancy unchanged. Pops on an empty FIFO are ignored.
// Reset is synchronous and active-low; stored words are not cleared, only the pointers.
//
// Ports:
//   clk_i, rst_ni      - clock, synchronous active-low reset
//   push_i, wdata_i    - write request and word
//   pop_i              - consume the head word
//   rdata_o            - head word (valid while !empty_o)
//   empty_o, full_o    - status flags
//
// Configuration macro: HOLD_BUF_DROP_EN has no effect in this file.

module hold_buf_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned Aw = $clog2(Depth);
    localparam logic [Aw:0] PtrOne = 1;

    logic [Aw:0]      wptr_q, wptr_d;
    logic [Aw:0]      rptr_q, rptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push is about to use.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q[Aw-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + PtrOne;
        end
        if (do_pop) begin
            rptr_d = rptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[Aw-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/packet_hold_buffer.sv
// Packet hold buffer: stores ingress AXI-Stream beats until the parser delivers a
// per-packet decision, then forwards (or, with HOLD_BUF_DROP_EN, discards) the packet.
//
// Ports:
//   axis_clk, aresetn             - clock, synchronous active-low reset
//   s_axis_t*                     - ingress stream (tdata/tkeep/tuser/tvalid/tlast, tready out)
//   m_axis_t*                     - egress stream (tdata/tkeep/tuser/tvalid/tlast, tready in)
//   parse_valid, parse_drop       - one decision pulse per packet, in packet order
//   pkt_fwd_cnt, pkt_drop_cnt     - wrapping 32-bit packet counters
//   err_dec_ovf                   - sticky: a decision arrived while the decision FIFO was full
//
// Configuration macro: HOLD_BUF_DROP_EN. Undefined: parse_drop is ignored, every packet is
// forwarded, the drop state does not exist and pkt_drop_cnt is tied to zero.

module packet_hold_buffer import hold_buf_pkg::*; #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = DefDataWidth,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = DefTuserWidth,
    parameter int unsigned C_FIFO_DEPTH         = 32,
    parameter int unsigned C_DEC_DEPTH          = 4
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic                              parse_valid,
    input  logic                              parse_drop,
    output logic [31:0]                       pkt_fwd_cnt,
    output logic [31:0]                       pkt_drop_cnt,
    output logic                              err_dec_ovf
);

    localparam int unsigned EntryW = entry_width(C_S_AXIS_DATA_WIDTH, C_S_AXIS_TUSER_WIDTH);

    state_e state_q, state_d;

    logic              rdy_q;
    logic              err_q;
    logic [31:0]       fwd_cnt_q;
    logic              fwd_inc;

    logic [EntryW-1:0] data_wdata;
    logic [EntryW-1:0] data_rdata;
    logic              data_push;
    logic              data_pop;
    logic              data_empty;
    logic              data_full;
    logic              head_last;

    logic              dec_wdata;
    logic              dec_rdata;
    logic              dec_pop;
    logic              dec_empty;
    logic              dec_full;

    // tready stays low during reset and rises on the first edge with aresetn high.
    assign s_axis_tready = rdy_q && !data_full;
    assign data_push     = s_axis_tvalid && s_axis_tready;
    assign data_wdata    = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = data_rdata;
    assign head_last     = data_rdata[0];

    hold_buf_fifo #(
        .Width (EntryW),
        .Depth (C_FIFO_DEPTH)
    ) u_data_fifo (
        .clk_i   (axis_clk),
        .rst_ni  (aresetn),
        .push_i  (data_push),
        .wdata_i (data_wdata),
        .pop_i   (data_pop),
        .rdata_o (data_rdata),
        .empty_o (data_empty),
        .full_o  (data_full)
    );

`ifdef HOLD_BUF_DROP_EN
    assign dec_wdata = parse_drop;
`else
    assign dec_wdata = 1'b0;
    logic unused_dec;
    assign unused_dec = ^{parse_drop, dec_rdata};
`endif

    hold_buf_fifo #(
        .Width (1),
        .Depth (C_DEC_DEPTH)
    ) u_dec_fifo (
        .clk_i   (axis_clk),
        .rst_ni  (aresetn),
        .push_i  (parse_valid),
        .wdata_i (dec_wdata),
        .pop_i   (dec_pop),
        .rdata_o (dec_rdata),
        .empty_o (dec_empty),
        .full_o  (dec_full)
    );

`ifdef HOLD_BUF_DROP_EN
    logic        drop_inc;
    logic [31:0] drop_cnt_q;
`endif

    always_comb begin
        state_d       = state_q;
        dec_pop       = 1'b0;
        data_pop      = 1'b0;
        m_axis_tvalid = 1'b0;
        fwd_inc       = 1'b0;
`ifdef HOLD_BUF_DROP_EN
        drop_inc      = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                // Only commit to a packet once its first beat is already stored.
                if (!dec_empty && !data_empty) begin
                    dec_pop = 1'b1;
`ifdef HOLD_BUF_DROP_EN
                    state_d = dec_rdata ? StDrop : StFwd;
`else
                    state_d = StFwd;
`endif
                end
            end
            StFwd: begin
                m_axis_tvalid = !data_empty;
                if (!data_empty && m_axis_tready) begin
                    data_pop = 1'b1;
                    if (head_last) begin
                        fwd_inc = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
`ifdef HOLD_BUF_DROP_EN
            StDrop: begin
                if (!data_empty) begin
                    data_pop = 1'b1;
                    if (head_last) begin
                        drop_inc = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            fwd_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            // A pop in the same cycle makes room, so the decision is not lost.
            if (parse_valid && dec_full && !dec_pop) begin
                err_q <= 1'b1;
            end
            if (fwd_inc) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

`ifdef HOLD_BUF_DROP_EN
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            drop_cnt_q <= '0;
        end else if (drop_inc) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end
    assign pkt_drop_cnt = drop_cnt_q;
`else
    assign pkt_drop_cnt = '0;
`endif

    assign pkt_fwd_cnt = fwd_cnt_q;
    assign err_dec_ovf = err_q;

endmodule

// File: tb/tb_packet_hold_buffer.sv
// Self-checking bench for packet_hold_buffer. Expected egress beats are queued when the
// ingress beat is driven; a negedge monitor queues observed handshakes; each test compares.
// Works with HOLD_BUF_DROP_EN either defined or undefined.

module tb_packet_hold_buffer;

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 8;
    localparam int unsigned BW = DW + DW / 8 + TW + 1;
`ifdef HOLD_BUF_DROP_EN
    localparam bit DropEn = 1'b1;
`else
    localparam bit DropEn = 1'b0;
`endif

    typedef logic [BW-1:0] beat_t;

    logic            axis_clk = 1'b0;
    logic            aresetn;
    logic [DW-1:0]   s_axis_tdata;
    logic [DW/8-1:0] s_axis_tkeep;
    logic [TW-1:0]   s_axis_tuser;
    logic            s_axis_tvalid;
    logic            s_axis_tlast;
    logic            s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tkeep;
    logic [TW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready;
    logic            parse_valid;
    logic            parse_drop;
    logic [31:0]     pkt_fwd_cnt;
    logic [31:0]     pkt_drop_cnt;
    logic            err_dec_ovf;

    int    total = 0;
    int    bad = 0;
    int    exp_fwd = 0;
    int    exp_drop = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    always #5 axis_clk = ~axis_clk;

    packet_hold_buffer #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (TW),
        .C_FIFO_DEPTH         (32),
        .C_DEC_DEPTH          (4)
    ) dut (
        .axis_clk      (axis_clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .parse_valid   (parse_valid),
        .parse_drop    (parse_drop),
        .pkt_fwd_cnt   (pkt_fwd_cnt),
        .pkt_drop_cnt  (pkt_drop_cnt),
        .err_dec_ovf   (err_dec_ovf)
    );

    // Inputs only change 1 time unit after posedge, so the negedge view matches the edge.
    always @(negedge axis_clk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            obs_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast});
        end
    end

    function automatic beat_t mk_beat(input int id, input int b, input bit last);
        logic [15:0] idv;
        logic [15:0] bv;
        idv = id[15:0];
        bv  = b[15:0];
        return {idv, bv, (last ? 4'h7 : 4'hf), idv[3:0], bv[3:0], last};
    endfunction

    // Holds the beat until accepted; the decision pulse lasts exactly one cycle.
    task automatic drive_beat(input beat_t bt, input bit pv, input bit pd);
        bit acc;
        acc = 1'b0;
        {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = bt;
        s_axis_tvalid = 1'b1;
        parse_valid   = pv;
        parse_drop    = pd;
        for (int c = 0; c < 500; c++) begin
            @(negedge axis_clk);
            acc = s_axis_tready;
            @(posedge axis_clk);
            #1;
            parse_valid = 1'b0;
            if (acc) break;
        end
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL ingress_accept got=0 exp=1");
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int id, input int nb, input int dec_at, input bit drop);
        bit    fwd;
        beat_t bt;
        fwd = !(drop && DropEn);
        for (int b = 0; b < nb; b++) begin
            bt = mk_beat(id, b, b == nb - 1);
            if (fwd) exp_q.push_back(bt);
            drive_beat(bt, b == dec_at, drop);
        end
        if (fwd) exp_fwd++;
        else exp_drop++;
    endtask

    task automatic wait_egress(input int extra);
        for (int c = 0; c < 2000; c++) begin
            if (obs_q.size() >= exp_q.size()) break;
            @(posedge axis_clk);
            #1;
        end
        repeat (extra) begin
            @(posedge axis_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) begin
            @(posedge axis_clk);
            #1;
        end
        total++;
        if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_s_tready got=%b exp=0", s_axis_tready); end
        total++;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_m_tvalid got=%b exp=0", m_axis_tvalid); end
        total++;
        if (pkt_fwd_cnt !== 32'd0 || pkt_drop_cnt !== 32'd0) begin
            bad++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", pkt_fwd_cnt, pkt_drop_cnt);
        end
        total++;
        if (err_dec_ovf !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_dec_ovf); end
        aresetn = 1'b1;
        @(posedge axis_clk);
        #1;
        total++;
        if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL rst_release_tready got=%b exp=1", s_axis_tready); end
    endtask

    task automatic test_single_fwd();
        beat_t e;
        beat_t o;
        m_axis_tready = 1'b1;
        send_pkt(1, 3, 0, 1'b0);
        wait_egress(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 'x;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL single_beat got=%h exp=%h", o, e); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL single_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
        total++;
        if (pkt_fwd_cnt !== 32'(exp_fwd)) begin bad++; $display("FAIL single_fwd_cnt got=%0d exp=%0d", pkt_fwd_cnt, exp_fwd); end
    endtask

    task automatic test_latency_hold();
        beat_t bt;
        beat_t e;
        beat_t o;
        m_axis_tready = 1'b0;
        bt = mk_beat(10, 0, 1'b1);
        exp_q.push_back(bt);
        drive_beat(bt, 1'b1, 1'b0);
        exp_fwd++;
        total++;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL lat_early_valid got=%b exp=0", m_axis_tvalid); end
        @(posedge axis_clk);
        #1;
        total++;
        if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b exp=1", m_axis_tvalid); end
        for (int i = 0; i < 3; i++) begin
            @(posedge axis_clk);
            #1;
            total++;
            if ({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} !== bt || m_axis_tvalid !== 1'b1) begin
                bad++;
                $display("FAIL hold_stable got=%h/%b exp=%h/1", {m_axis_tdata, m_axis_tkeep, m_axis_tuser,
                         m_axis_tlast}, m_axis_tvalid, bt);
            end
        end
        m_axis_tready = 1'b1;
        wait_egress(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 'x;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL lat_beat got=%h exp=%h", o, e); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL lat_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
        total++;
        if (pkt_fwd_cnt !== 32'(exp_fwd)) begin bad++; $display("FAIL lat_fwd_cnt got=%0d exp=%0d", pkt_fwd_cnt, exp_fwd); end
    endtask

    task automatic test_drop();
        beat_t e;
        beat_t o;
        m_axis_tready = 1'b1;
        send_pkt(2, 3, 0, 1'b1);
        send_pkt(3, 2, 1, 1'b0);
        wait_egress(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 'x;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL drop_beat got=%h exp=%h", o, e); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL drop_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
        total++;
        if (pkt_fwd_cnt !== 32'(exp_fwd)) begin bad++; $display("FAIL drop_fwd_cnt got=%0d exp=%0d", pkt_fwd_cnt, exp_fwd); end
        total++;
        if (pkt_drop_cnt !== 32'(exp_drop)) begin bad++; $display("FAIL drop_cnt got=%0d exp=%0d", pkt_drop_cnt, exp_drop); end
    endtask

    task automatic test_backpressure();
        beat_t bt;
        beat_t e;
        beat_t o;
        m_axis_tready = 1'b0;
        for (int b = 0; b < 32; b++) begin
            bt = mk_beat(40, b, b == 31);
            exp_q.push_back(bt);
            drive_beat(bt, b == 0, 1'b0);
            if (b >= 30) begin
                total++;
                if (s_axis_tready !== (b == 30)) begin
                    bad++; $display("FAIL bp_tready_beat%0d got=%b exp=%b", b + 1, s_axis_tready, b == 30);
                end
            end
        end
        exp_fwd++;
        m_axis_tready = 1'b1;
        @(posedge axis_clk);
        #1;
        m_axis_tready = 1'b0;
        total++;
        if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL bp_tready_after_pop got=%b exp=1", s_axis_tready); end
        total++;
        if (obs_q.size() != 1) begin bad++; $display("FAIL bp_single_pop got=%0d exp=1", obs_q.size()); end
        m_axis_tready = 1'b1;
        wait_egress(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 'x;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL bp_beat got=%h exp=%h", o, e); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL bp_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
        total++;
        if (pkt_fwd_cnt !== 32'(exp_fwd)) begin bad++; $display("FAIL bp_fwd_cnt got=%0d exp=%0d", pkt_fwd_cnt, exp_fwd); end
    endtask

    task automatic test_dec_overflow();
        bit    decs[5];
        beat_t bt;
        beat_t e;
        beat_t o;
        decs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            parse_valid = 1'b1;
            parse_drop  = decs[i];
            @(posedge axis_clk);
            #1;
            parse_valid = 1'b0;
            if (i >= 3) begin
                total++;
                if (err_dec_ovf !== (i == 4)) begin
                    bad++; $display("FAIL ovf_flag_pulse%0d got=%b exp=%b", i + 1, err_dec_ovf, i == 4);
                end
            end
        end
        m_axis_tready = 1'b1;
        for (int p = 0; p < 5; p++) begin
            bt = mk_beat(50 + p, 0, 1'b1);
            if (p < 4) begin
                if (decs[p] && DropEn) exp_drop++;
                else begin
                    exp_fwd++;
                    exp_q.push_back(bt);
                end
            end
            drive_beat(bt, 1'b0, 1'b0);
        end
        wait_egress(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 'x;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL ovf_beat got=%h exp=%h", o, e); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL ovf_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
        total++;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL ovf_held_valid got=%b exp=0", m_axis_tvalid); end
        total++;
        if (pkt_fwd_cnt !== 32'(exp_fwd)) begin bad++; $display("FAIL ovf_fwd_cnt got=%0d exp=%0d", pkt_fwd_cnt, exp_fwd); end
        total++;
        if (pkt_drop_cnt !== 32'(exp_drop)) begin bad++; $display("FAIL ovf_drop_cnt got=%0d exp=%0d", pkt_drop_cnt, exp_drop); end
        total++;
        if (err_dec_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", err_dec_ovf); end
    endtask

    task automatic test_mid_reset();
        beat_t e;
        beat_t o;
        m_axis_tready = 1'b1;
        // Two beats of a 4-beat packet; counters and the sticky error are non-zero here.
        drive_beat(mk_beat(60, 0, 1'b0), 1'b1, 1'b0);
        drive_beat(mk_beat(60, 1, 1'b0), 1'b0, 1'b0);
        aresetn = 1'b0;
        @(posedge axis_clk);
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", m_axis_tvalid); end
        total++;
        if (pkt_fwd_cnt !== 32'd0 || pkt_drop_cnt !== 32'd0) begin
            bad++; $display("FAIL mid_rst_counts got=%0d/%0d exp=0/0", pkt_fwd_cnt, pkt_drop_cnt);
        end
        total++;
        if (err_dec_ovf !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%b exp=0", err_dec_ovf); end
        total++;
        if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL mid_rst_tready got=%b exp=0", s_axis_tready); end
        @(posedge axis_clk);
        #1;
        exp_q.delete();
        obs_q.delete();
        exp_fwd  = 0;
        exp_drop = 0;
        aresetn  = 1'b1;
        @(posedge axis_clk);
        #1;
        send_pkt(61, 3, 0, 1'b0);
        wait_egress(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = 'x;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL mid_beat got=%h exp=%h", o, e); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL mid_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
        total++;
        if (pkt_fwd_cnt !== 32'(exp_fwd)) begin bad++; $display("FAIL mid_fwd_cnt got=%0d exp=%0d", pkt_fwd_cnt, exp_fwd); end
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        parse_valid   = 1'b0;
        parse_drop    = 1'b0;
        test_reset();
        test_single_fwd();
        test_latency_hold();
        test_drop();
        test_backpressure();
        test_dec_overflow();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
